// File: rtl/detector_scheduler.sv
// detector_scheduler: arbitrates two requesters onto one enable-less sequence detector,
// buffering each burst and replaying it gap-free from a cleared detector to count led hits.
module detector_scheduler #(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  input  logic [3:0]    req_sym,
  input  logic [1:0]    req_last,
  output logic [1:0]    req_ready,
  output logic [1:0]    det_x,
  output logic          det_clr,
  input  logic          det_led,
  output logic          res_valid,
  output logic          res_id,
  output logic          res_hit,
  output logic [CW-1:0] res_count,
  output logic          res_ovf,
  output logic          busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, DRAIN, REPORT} state_t;
  state_t state_q, state_d;
  logic g_q, g_d, prio_q, prio_d;
  logic [CW-1:0] n_q, n_d, k_q, k_d, count_q, count_d, n_inc, k_inc;
  logic ovf_q, ovf_d;
  logic [1:0] det_x_q, det_x_d, sym, play_sym;
  logic det_clr_q, det_clr_d;
  logic res_valid_q, res_valid_d, res_id_q, res_id_d, res_hit_q, res_hit_d, res_ovf_q, res_ovf_d;
  logic [CW-1:0] res_count_q, res_count_d;
  logic hs, samp, wr_en, rep;
  logic [1:0] buf_q [DEPTH];
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    prio_d = prio_q;
    n_d = n_q;
    k_d = k_q;
    count_d = count_q;
    ovf_d = ovf_q;
    wr_en = 1'b0;
    sym = g_q ? req_sym[3:2] : req_sym[1:0];
    hs = state_q == LOAD && req_valid[g_q];
    n_inc = n_q + CW'(1);
    k_inc = k_q + CW'(1);
    samp = ((state_q == PLAY && k_q != '0) || state_q == DRAIN) && det_led;
    case (state_q)
      IDLE: if (|req_valid) begin
        // prio_q names the requester that wins the next tie
        g_d = &req_valid ? prio_q : req_valid[1];
        prio_d = ~g_d;
        state_d = LOAD;
      end
      LOAD: if (hs) begin
        wr_en = 1'b1;
        n_d = n_inc;
        if (req_last[g_q] || n_inc == CW'(DEPTH)) begin
          state_d = PLAY;
          k_d = '0;
          ovf_d = ~req_last[g_q];
        end
      end
      PLAY: begin
        k_d = k_inc;
        state_d = k_inc == n_q ? DRAIN : PLAY;
      end
      DRAIN: state_d = REPORT;
      REPORT: begin
        state_d = IDLE;
        n_d = '0;
        count_d = '0;
        ovf_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (samp && count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
    play_sym = state_q == LOAD ? (n_q == '0 ? sym : buf_q[0]) : buf_q[AW'(k_inc)];
    det_x_d = state_d == PLAY ? play_sym : 2'b00;
    det_clr_d = !(state_d == PLAY || state_d == DRAIN);
    rep = state_d == REPORT;
    res_valid_d = rep;
    res_id_d = rep ? g_q : res_id_q;
    res_count_d = rep ? count_d : res_count_q;
    res_hit_d = rep ? count_d != '0 : res_hit_q;
    res_ovf_d = rep ? ovf_q : res_ovf_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      g_q <= 1'b0;
      prio_q <= 1'b1;
      n_q <= '0;
      k_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      det_x_q <= 2'b00;
      det_clr_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_id_q <= 1'b0;
      res_hit_q <= 1'b0;
      res_count_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      prio_q <= prio_d;
      n_q <= n_d;
      k_q <= k_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      det_x_q <= det_x_d;
      det_clr_q <= det_clr_d;
      res_valid_q <= res_valid_d;
      res_id_q <= res_id_d;
      res_hit_q <= res_hit_d;
      res_count_q <= res_count_d;
      res_ovf_q <= res_ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[AW'(n_q)] <= sym;
  end
  assign req_ready = state_q == LOAD ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy = state_q != IDLE;
  assign det_x = det_x_q;
  assign det_clr = det_clr_q;
  assign res_valid = res_valid_q;
  assign res_id = res_id_q;
  assign res_hit = res_hit_q;
  assign res_count = res_count_q;
  assign res_ovf = res_ovf_q;
endmodule

// File: tb/tb_detector_scheduler.sv
// tb_detector_scheduler: directed bench with a behavioural detector recognising 11,10,10,01,01
// (led in state 5, held while 01 keeps arriving) and hand-computed burst results.
module tb_detector_scheduler;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH + 1);
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] req_valid, req_last, req_ready, det_x;
  logic [3:0] req_sym;
  logic det_clr, det_led, res_valid, res_id, res_hit, res_ovf, busy;
  logic [CW-1:0] res_count;
  int checks = 0, failures = 0, cyc = 0, nres = 0, both_rdy = 0;
  logic [2:0] ds;
  logic [1:0] seen [$];

  detector_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_sym(req_sym), .req_last(req_last),
    .req_ready(req_ready), .det_x(det_x), .det_clr(det_clr), .det_led(det_led),
    .res_valid(res_valid), .res_id(res_id), .res_hit(res_hit), .res_count(res_count),
    .res_ovf(res_ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] nxt(input logic [2:0] s, input logic [1:0] x);
    logic [1:0] want;
    want = s == 3'd0 ? 2'b11 : (s == 3'd1 || s == 3'd2) ? 2'b10 : 2'b01;
    return x == want ? (s == 3'd5 ? 3'd5 : s + 3'd1) : (x == 2'b11 ? 3'd1 : 3'd0);
  endfunction

  always @(posedge clk or posedge det_clr)
    if (det_clr) ds <= 3'd0;
    else ds <= nxt(ds, det_x);
  assign det_led = ds == 3'd5;

  always @(negedge clk) begin
    if (!det_clr) seen.push_back(det_x);
    if (res_valid) nres++;
    if (req_ready == 2'b11) both_rdy++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input string tag, input int id, input logic [31:0] v, input int n,
                      input bit lastf, input int acc, output int c0);
    int i = 0, t = 0;
    c0 = 0;
    seen.delete();
    req_valid[id] = 1'b1;
    req_sym[2*id+:2] = v[1:0];
    req_last[id] = lastf && n == 1;
    while (i < acc && t < 200) begin
      @(negedge clk);
      t++;
      if (req_ready[id]) begin
        @(posedge clk);
        #1;
        i++;
        c0 = cyc;
        if (i < n) begin
          req_sym[2*id+:2] = v[2*i+:2];
          req_last[id] = lastf && i == n - 1;
        end
      end
    end
    chk({tag, "_accepted"}, i, acc);
    if (i < n) begin
      @(negedge clk);
      chk({tag, "_ready_drop"}, {30'd0, req_ready}, 0);
    end
    req_valid[id] = 1'b0;
    req_last[id] = 1'b0;
    req_sym[2*id+:2] = 2'b00;
  endtask

  task automatic result(input string tag, input int id, input logic [31:0] v, input int n,
                        input int c0, input int cnt, input bit ovf);
    int t = 0;
    bit ok;
    do begin
      @(negedge clk);
      t++;
    end while (!res_valid && t < 100);
    chk({tag, "_res_valid"}, res_valid, 1);
    chk({tag, "_res_id"}, res_id, id);
    chk({tag, "_res_count"}, res_count, cnt);
    chk({tag, "_res_hit"}, res_hit, cnt != 0);
    chk({tag, "_res_ovf"}, res_ovf, ovf);
    chk({tag, "_latency"}, cyc, c0 + n + 1);
    ok = seen.size() == n + 1;
    for (int k = 0; k < seen.size() && k <= n; k++)
      ok &= seen[k] === (k < n ? v[2*k+:2] : 2'b00);
    chk({tag, "_replay"}, ok, 1);
    @(negedge clk);
    chk({tag, "_pulse"}, res_valid, 0);
  endtask

  initial begin
    int c0, snap, t;
    req_valid = 2'b00;
    req_sym = 4'h0;
    req_last = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_det_clr", det_clr, 1);
    chk("rst_det_x", det_x, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_fields", {res_id, res_hit, res_ovf, res_count}, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    load("t1", 0, 32'b01_01_10_10_11, 5, 1'b1, 5, c0);
    result("t1", 0, 32'b01_01_10_10_11, 5, c0, 1, 1'b0);
    load("t2", 1, 32'b01_01_01_10_10_11, 6, 1'b1, 6, c0);
    result("t2", 1, 32'b01_01_01_10_10_11, 6, c0, 2, 1'b0);
    load("t3", 0, 32'b00_00_00, 3, 1'b1, 3, c0);
    result("t3", 0, 32'b00_00_00, 3, c0, 0, 1'b0);
    load("t5", 0, 32'b11_00_01_01_01_01_10_10_11, 9, 1'b0, 8, c0);
    result("t5", 0, 32'b11_00_01_01_01_01_10_10_11, 8, c0, 3, 1'b1);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 2'b11;
    req_last = 2'b11;
    req_sym = 4'h0;
    for (int r = 0; r < 4; r++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!res_valid && t < 50);
      chk("t4_res_valid", res_valid, 1);
      chk("t4_grant", res_id, r % 2 == 0 ? 1 : 0);
      chk("t4_count", res_count, 0);
      @(negedge clk);
    end
    req_valid = 2'b00;
    req_last = 2'b00;
    chk("t4_single_ready", both_rdy, 0);
    repeat (4) @(negedge clk);

    load("t6", 0, 32'b01_01_10_10_11, 5, 1'b1, 5, c0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t6_in_play", det_clr, 0);
    snap = nres;
    reset = 1'b1;
    #1;
    chk("t6_det_clr", det_clr, 1);
    chk("t6_det_x", det_x, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_no_result", nres, snap);
    chk("t6_idle", busy, 0);
    load("t6b", 0, 32'b01_01_10_10_11, 5, 1'b1, 5, c0);
    result("t6b", 0, 32'b01_01_10_10_11, 5, c0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
